// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-in/parallel-out receive controller.
// Contents:
//   state_t       - controller FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH - default number of bits per assembled word
package sipo_rx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_stage.sv
// WIDTH-bit right-shift register. The serial input enters at the MSB, so
// after WIDTH shifts the first received bit sits in bit 0.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears the register
//   clr   - synchronous clear (takes priority over en)
//   en    - shift enable
//   sin   - serial input bit
//   word  - value the register takes on the next enabled shift
//           ({sin, q[WIDTH-1:1]}); used by the controller to capture the
//           completed word on the same edge as the final bit
module sipo_shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] q_r;

  // Dropping the LSB of {sin, q_r} is the right shift; the outgoing bit is
  // simply discarded.
  assign word = WIDTH'({sin, q_r} >> 1);

  // Shift register state: reset, clear, shift or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      q_r <= {WIDTH{1'b0}};
    end else if (en) begin
      q_r <= word;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Sequencing controller for a serial-in/parallel-out receiver. A start
// request in IDLE opens a capture of exactly WIDTH qualified serial bits;
// the completed word is moved into a one-deep holding register and offered
// downstream with a valid/ready handshake. A word completing while the
// holding register is still occupied and not being drained is dropped and
// flagged on the sticky overrun output.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   start      - begin capturing one word (sampled only in IDLE)
//   sin        - serial data bit
//   sin_valid  - sin is qualified this cycle (only counted in SHIFT)
//   dout       - assembled word, first received bit in dout[0]
//   dout_valid - holding register contains an unconsumed word
//   dout_ready - consumer accepts dout this cycle
//   busy       - high while in SHIFT
//   overrun    - sticky flag, set when a completed word is dropped
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             clr_s;
  logic             shift_en_s;
  logic             word_done_s;
  logic [WIDTH-1:0] word_s;

  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic             xfer_s;
  logic             load_s;
  logic             drop_s;
  logic             dout_valid_next_s;

  sipo_shift_stage #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (shift_en_s),
    .sin   (sin),
    .word  (word_s)
  );

  // Next-state, bit counter and shift-stage control.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    clr_s        = 1'b0;
    shift_en_s   = 1'b0;
    word_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // sin/sin_valid are deliberately ignored here, even with start.
        if (start) begin
          state_next_s = SHIFT;
          cnt_next_s   = {CNT_W{1'b0}};
          clr_s        = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        // start is ignored; gaps in sin_valid hold everything.
        if (sin_valid) begin
          shift_en_s = 1'b1;
          if (cnt_r == CNT_MAX) begin
            word_done_s  = 1'b1;
            state_next_s = IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Holding-register handshake: a completing word loads if the register is
  // free or is being drained on this very edge; otherwise it is dropped.
  always_comb begin
    xfer_s = dout_valid_r & dout_ready;
    load_s = word_done_s & (~dout_valid_r | dout_ready);
    drop_s = word_done_s & dout_valid_r & ~dout_ready;
    if (load_s) begin
      dout_valid_next_s = 1'b1;
    end else if (xfer_s) begin
      dout_valid_next_s = 1'b0;
    end else begin
      dout_valid_next_s = dout_valid_r;
    end
  end

  // FSM, counter, holding register and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      dout_valid_r <= dout_valid_next_s;
      busy_r       <= (state_next_s == SHIFT);
      // dout keeps its value after a transfer; only a load changes it.
      if (load_s) begin
        dout_r <= word_s;
      end else begin
        dout_r <= dout_r;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule
